// File: rtl/m_ff_pipe.sv
// WIDTH x DEPTH register pipeline with per-stage valid bits and collapsing bubbles.
// Optional FLUSH input is enabled by defining M_FF_PIPE_FLUSH_EN.
module m_ff_pipe #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       DEPTH    = 2,
  parameter bit                NEG_EDGE = 1'b0,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
  input  logic                         CK,
  input  logic                         R,
  input  logic                         I_VALID,
  output logic                         I_READY,
  input  logic [WIDTH-1:0]             D,
  output logic                         O_VALID,
  input  logic                         O_READY,
`ifdef M_FF_PIPE_FLUSH_EN
  input  logic                         FLUSH,
`endif
  output logic [WIDTH-1:0]             Q,
  output logic [$clog2(DEPTH+1)-1:0]   OCC
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] r_d     [DEPTH];
  logic [WIDTH-1:0] w_d_nxt [DEPTH];
  logic [WIDTH-1:0] w_dsrc  [DEPTH+1];
  logic [DEPTH:0]   w_vcat;
  logic [DEPTH:0]   w_rdy;
  logic [OW-1:0]    r_occ;
  logic [OW-1:0]    w_occ_nxt;
  logic             w_flush;
  logic             w_ovalid;
  logic             w_acc;
  logic             w_emit;

`ifdef M_FF_PIPE_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  // A stage can load when it is empty or its successor can load this cycle.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = O_READY;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_rdy[DEPTH-1-i] = ~r_v[DEPTH-1-i] | w_rdy[DEPTH-i];
    end
  end

  assign w_vcat    = {r_v, I_VALID};
  assign w_ovalid  = r_v[DEPTH-1] & ~w_flush;
  assign I_READY   = w_rdy[0] & ~w_flush;
  assign w_acc     = I_VALID & I_READY;
  assign w_emit    = w_ovalid & O_READY;

  always_comb begin
    w_dsrc[0] = D;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_dsrc[k+1] = r_d[k];
    end
  end

  always_comb begin
    w_v_nxt = r_v;
    w_d_nxt = r_d;
    if (w_flush) begin
      w_v_nxt = '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          w_v_nxt[k] = w_vcat[k];
          if (w_vcat[k]) begin
            w_d_nxt[k] = w_dsrc[k];
          end
        end
      end
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_flush) begin
      w_occ_nxt = '0;
    end else if (w_acc && !w_emit) begin
      w_occ_nxt = r_occ + 1'b1;
    end else if (!w_acc && w_emit) begin
      w_occ_nxt = r_occ - 1'b1;
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge CK or posedge R) begin
        if (R) begin
          r_v   <= '0;
          r_occ <= '0;
          for (int unsigned k = 0; k < DEPTH; k++) begin
            r_d[k] <= RST_VAL;
          end
        end else begin
          r_v   <= w_v_nxt;
          r_occ <= w_occ_nxt;
          r_d   <= w_d_nxt;
        end
      end
    end else begin : g_pos
      always_ff @(posedge CK or posedge R) begin
        if (R) begin
          r_v   <= '0;
          r_occ <= '0;
          for (int unsigned k = 0; k < DEPTH; k++) begin
            r_d[k] <= RST_VAL;
          end
        end else begin
          r_v   <= w_v_nxt;
          r_occ <= w_occ_nxt;
          r_d   <= w_d_nxt;
        end
      end
    end
  endgenerate

  assign O_VALID = w_ovalid;
  assign Q       = r_d[DEPTH-1];
  assign OCC     = r_occ;

endmodule

// File: tb/tb_m_ff_pipe.sv
// Scoreboard bench for m_ff_pipe: several depths, one falling-edge instance,
// and the flush path when M_FF_PIPE_FLUSH_EN is defined.
module tb_m_ff_pipe;

  localparam int NI = 5;
  localparam logic [7:0] RV = 8'h5A;

  function automatic int dep(input int j);
    case (j)
      0: return 3;
      1: return 3;
      2: return 1;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          iv;
  logic [7:0]    din;
  logic          ordy;
  logic          flush;
  int            sel;

  logic [NI-1:0] w_ov;
  logic [NI-1:0] w_ir;
  logic [7:0]    w_q   [NI];
  logic [2:0]    w_occ [NI];

  logic [7:0]    sb [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          prev_stall;
  logic [7:0]    prev_q;

  always #5 clk = ~clk;

  generate
    for (genvar j = 0; j < NI; j++) begin : g_dut
      localparam int DP = dep(j);
      localparam int OW = $clog2(DP + 1);
      logic [OW-1:0] occ;
      logic          ivj;
      assign ivj = iv & (sel == j);
      m_ff_pipe #(
        .WIDTH    (8),
        .DEPTH    (DP),
        .NEG_EDGE (j == 1),
        .RST_VAL  (RV)
      ) u_dut (
        .CK      (clk),
        .R       (rst),
        .I_VALID (ivj),
        .I_READY (w_ir[j]),
        .D       (din),
        .O_VALID (w_ov[j]),
        .O_READY (ordy),
`ifdef M_FF_PIPE_FLUSH_EN
        .FLUSH   (flush),
`endif
        .Q       (w_q[j]),
        .OCC     (occ)
      );
      assign w_occ[j] = 3'(occ);
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer cycle on the selected instance: score emit/accept, then the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic       ov;
    logic       ir;
    logic [7:0] q;
    iv   = v;
    din  = d;
    ordy = r;
    #1;
    ov = w_ov[sel];
    ir = w_ir[sel];
    q  = w_q[sel];
    if (prev_stall && !flush) begin
      check("hold_valid", 32'(ov), 32'd1);
      check("hold_q", 32'(q), 32'(prev_q));
    end
    if (ov && r) begin
      if (sb.size() == 0) check("spurious_emit", 32'(ov), 32'd0);
      else check("q_order", 32'(q), 32'(sb.pop_front()));
    end
    if (v && ir) sb.push_back(d);
    prev_stall = ov & ~r;
    prev_q     = q;
    if (sel == 1) @(negedge clk);
    else @(posedge clk);
    #2;
    if (flush) begin
      sb.delete();
      prev_stall = 1'b0;
    end
    check("occ", 32'(w_occ[sel]), 32'(sb.size()));
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_ovalid", 32'(w_ov[sel]), 32'd0);
    check("rst_q", 32'(w_q[sel]), 32'(RV));
    check("rst_occ", 32'(w_occ[sel]), 32'd0);
    check("rst_iready", 32'(w_ir[sel]), 32'd1);
    sb.delete();
    prev_stall = 1'b0;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; din = '0; ordy = 1'b0; flush = 1'b0;
    sel = 0; prev_stall = 1'b0; prev_q = '0;
    #3;
    for (int j = 0; j < NI; j++) begin
      check("init_ovalid", 32'(w_ov[j]), 32'd0);
      check("init_q", 32'(w_q[j]), 32'(RV));
      check("init_occ", 32'(w_occ[j]), 32'd0);
    end
    #4 rst = 1'b0;
    @(posedge clk);
    #2;

    // Back-to-back stream 1..10, DEPTH=3, rising then falling edge instance.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 13; i++) begin
        check("lat_ovalid", 32'(w_ov[sel]), 32'(i >= 3));
        step(i < 10, 8'(i + 1), 1'b1);
      end
    end

    // Back-pressure: fill with O_READY low, fourth word blocked, then drain.
    sel = 0;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    check("full_iready", 32'(w_ir[0]), 32'd0);
    check("full_occ", 32'(w_occ[0]), 32'd3);
    check("full_ovalid", 32'(w_ov[0]), 32'd1);
    check("full_q", 32'(w_q[0]), 32'hA1);
    step(1'b1, 8'hA4, 1'b0);
    step(1'b1, 8'hA4, 1'b0);
    check("still_full_iready", 32'(w_ir[0]), 32'd0);
    step(1'b1, 8'hA4, 1'b1);
    check("swap_occ", 32'(w_occ[0]), 32'd3);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    check("drained_ovalid", 32'(w_ov[0]), 32'd0);

    // Asynchronous reset with three words in flight.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      check("pre_rst_occ", 32'(w_occ[sel]), 32'd3);
      pulse_reset();
    end

    // Random flow control on DEPTH=1,2,4,3.
    for (int s = 2; s < 6; s++) begin
      sel = (s == 5) ? 0 : s;
      repeat (2000) begin
        step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);
      end
      repeat (dep(sel) + 2) step(1'b0, 8'h00, 1'b1);
      check("rand_all_out", 32'(sb.size()), 32'd0);
    end

`ifdef M_FF_PIPE_FLUSH_EN
    sel = 0;
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    check("pre_flush_occ", 32'(w_occ[0]), 32'd2);
    flush = 1'b1;
    #1;
    check("flush_iready", 32'(w_ir[0]), 32'd0);
    check("flush_ovalid", 32'(w_ov[0]), 32'd0);
    step(1'b1, 8'h43, 1'b1);
    flush = 1'b0;
    check("post_flush_ovalid", 32'(w_ov[0]), 32'd0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("post_flush_first_v", 32'(w_ov[0]), 32'd1);
    check("post_flush_first_q", 32'(w_q[0]), 32'h77);
    step(1'b0, 8'h00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
